// File: rtl/instr_fetch_unit.sv
// RV32 instruction fetch stage: PC, credit-limited in-order imem requests, and an instruction buffer toward decode.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect target halts fetch and raises a sticky misalign_err.
module instr_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            misalign_err
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  cnt_t            count_q, count_d;
  cnt_t            outst_q, outst_d;
  cnt_t            drop_q, drop_d;
  ptr_t            buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  ptr_t            tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic            halt_q, halt_d;

  entry_t          buf_mem [BUF_DEPTH];
  logic [XLEN-1:0] tag_mem [BUF_DEPTH];

  logic            pop, push, req_fire;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] target_pc;
  entry_t          head;

  assign head     = buf_mem[buf_rd_q];
  assign id_valid = (count_q != '0);
  assign id_instr = id_valid ? head.instr : '0;
  assign id_pc    = id_valid ? head.pc : '0;
  assign pop      = id_valid & id_ready;

  // A slot popped this cycle is free again before any newly requested word can return,
  // so it is counted as available; this keeps a 1-cycle imem streaming at full rate.
  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q} - (CW+1)'(pop);
  assign imem_req_valid = !rst && !redirect_valid && !halt_q && (credit_used < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign push      = imem_rsp_valid && (drop_q == '0) && !redirect_valid && !halt_q;
  assign target_pc = redirect_pc & ~(XLEN'(3));

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_err = halt_q;
`else
  assign misalign_err = 1'b0;
`endif

  // NOTE: every variable gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q + cnt_t'(push) - cnt_t'(pop);
    outst_d  = outst_q + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
    drop_d   = drop_q;
    buf_wr_d = buf_wr_q;
    buf_rd_d = buf_rd_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    halt_d   = halt_q;

    if (req_fire) begin
      pc_d     = pc_q + XLEN'(4);
      tag_wr_d = tag_wr_q + ptr_t'(1);
    end
    // Every response retires its request tag, whether kept or dropped.
    if (imem_rsp_valid) begin
      tag_rd_d = tag_rd_q + ptr_t'(1);
      if (drop_q != '0) drop_d = drop_q - cnt_t'(1);
    end
    if (push) buf_wr_d = buf_wr_q + ptr_t'(1);
    if (pop)  buf_rd_d = buf_rd_q + ptr_t'(1);

    if (redirect_valid) begin
      pc_d     = target_pc;
      count_d  = '0;
      buf_wr_d = '0;
      buf_rd_d = '0;
      drop_d   = outst_q - cnt_t'(imem_rsp_valid);
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) halt_d = 1'b1;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      buf_wr_q <= '0;
      buf_rd_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      halt_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      buf_wr_q <= buf_wr_d;
      buf_rd_q <= buf_rd_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      halt_q   <= halt_d;
    end
  end

  // NOTE: storage arrays are not reset; occupancy counters qualify every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr_q] <= pc_q;
    if (push)     buf_mem[buf_wr_q] <= '{instr: imem_rsp_data, pc: tag_mem[tag_rd_q]};
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a latency-programmable imem model and an expected-PC-stream scoreboard.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .misalign_err(misalign_err)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        rspq[$];
  int          checks, failures;
  int          cyc, lat, delivered, accepts;
  logic [31:0] exp_pc, exp_req, prev_pc, prev_instr;
  bit          halted_exp, prev_stall, prev_redir, last_valid, last_rsp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs just after posedge, check on negedge, update the model.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt, input bit mrdy);
    bit rsp_now;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_req_ready = mrdy;
    rsp_now        = (rspq.size() > 0) && (rspq[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? (rspq[0].addr ^ KEY) : 32'h0;
    @(negedge clk);
    last_valid = id_valid;
    last_rsp   = rsp_now;
    if (prev_redir || halted_exp) begin
      check("flush_valid", 32'(id_valid), 0);
    end else if (prev_stall) begin
      check("hold_valid", 32'(id_valid), 1);
      check("hold_pc", id_pc, prev_pc);
      check("hold_instr", id_instr, prev_instr);
    end
    if (redir || halted_exp) check("no_req", 32'(imem_req_valid), 0);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_req);
    if (id_valid && rdy && !redir) begin
      check("id_pc", id_pc, exp_pc);
      check("id_instr", id_instr, exp_pc ^ KEY);
      exp_pc += 32'd4;
      delivered++;
    end
    if (imem_req_valid && mrdy) begin
      rspq.push_back('{addr: imem_req_addr, due: cyc + lat});
      exp_req += 32'd4;
      accepts++;
      check("credit", 32'(rspq.size() <= DEPTH), 1);
    end
    check("misalign_err", 32'(misalign_err), 32'(halted_exp));
    if (rsp_now) void'(rspq.pop_front());
    prev_stall = id_valid && !rdy && !redir;
    prev_pc    = id_pc;
    prev_instr = id_instr;
    prev_redir = redir;
    if (redir) begin
      exp_pc  = tgt & ~32'h3;
      exp_req = exp_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) halted_exp = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int ncyc);
    rst            = 1'b1;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    rspq.delete();
    repeat (ncyc) begin
      @(negedge clk);
      check("rst_id_valid", 32'(id_valid), 0);
      check("rst_req_valid", 32'(imem_req_valid), 0);
      check("rst_id_pc", id_pc, 0);
      check("rst_id_instr", id_instr, 0);
      check("rst_misalign", 32'(misalign_err), 0);
    end
    @(posedge clk);
    #1;
    rst        = 1'b0;
    cyc        = 0;
    exp_pc     = 32'h0;
    exp_req    = 32'h0;
    halted_exp = 1'b0;
    prev_stall = 1'b0;
    prev_redir = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, a0;
    checks = 0; failures = 0; delivered = 0; accepts = 0; lat = 1;
    do_reset(3);

    // Stream: 1-cycle imem, decode always ready -> first instruction at cycle 2, then one per cycle.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      check("stream_valid", 32'(last_valid), 32'(k >= 2));
    end

    // Backpressure for 5 cycles.
    a0 = accepts;
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_accepts", 32'(accepts - a0 <= DEPTH), 1);
    d0 = delivered;
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);
    check("bp_resume", 32'(delivered - d0 >= 8), 1);

    // Redirect with two fetches in flight on a 3-cycle imem.
    lat = 3;
    for (int i = 0; i < 20 && rspq.size() != 2; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    check("inflight_two", rspq.size(), 2);
    step(1'b1, 1'b1, 32'h100, 1'b1);
    d0 = delivered;
    repeat (20) step(1'b1, 1'b0, 32'h0, 1'b1);
    check("redir_progress", 32'(delivered - d0 >= 2), 1);

    // Redirect in the same cycle as a response and a pop.
    lat = 1;
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h200, 1'b1);
    check("coinc_rsp", 32'(last_rsp), 1);
    check("coinc_pop", 32'(last_valid), 1);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);

    // PC wrap across 2^32.
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    d0 = delivered;
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    check("wrap_progress", 32'(delivered - d0 >= 3), 1);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check("async_id_valid", 32'(id_valid), 0);
    check("async_req_valid", 32'(imem_req_valid), 0);
    do_reset(2);
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    check("post_rst_pc", exp_pc, 32'h10);

    // Randomized traffic with occasional redirects.
    d0 = delivered;
    for (int i = 0; i < 800; i++) begin
      logic [31:0] tgt;
      bit          redir;
      if (i % 50 == 0) lat = int'($urandom_range(3, 1));
      redir = ($urandom_range(29, 0) == 0);
      tgt   = $urandom();
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      step($urandom_range(2, 0) != 0, redir, tgt, $urandom_range(3, 0) != 0);
    end
    check("random_progress", 32'(delivered - d0 > 100), 1);

    // Misaligned redirect target.
    lat = 1;
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h102, 1'b1);
    a0 = accepts;
    d0 = delivered;
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("halt_no_accepts", accepts - a0, 0);
    check("halt_no_output", delivered - d0, 0);
`else
    check("misalign_progress", 32'(delivered - d0 >= 7), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
